adder_pipe_arbiter: RTL
=======================

// Module: adder_pipe_arbiter
// PURPOSE
//   Shares one external pipelined adder (fixed latency LAT, no stall) among N_REQ
//   requesters. Arbitrates round-robin, issues at most one add per cycle, and tracks
//   each in-flight operation's owner tag through a LAT-deep shift register.
//   Routes each sum/carry back to its owner. Sits between client blocks and the
//   shared adder datapath.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8)
//   WIDTH  4  operand/sum width
//   LAT    4  adder latency: add_a/add_b presented in cycle k -> add_sum/add_c valid in cycle k+LAT
// PORTS
//   CLK      in   1              clock, rising edge
//   RST_n    in   1              reset, asynchronous, active-low
//   en       in   1              1 = grants allowed; 0 = no new grants, in-flight ops drain
//   req      in   N_REQ          request per requester, held until granted
//   req_a    in   N_REQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b    in   N_REQ*WIDTH    operand B, same packing
//   gnt      out  N_REQ          one-hot grant (combinational); operands taken at this edge
//   add_a    out  WIDTH          registered operand A to adder
//   add_b    out  WIDTH          registered operand B to adder
//   add_sum  in   WIDTH          adder sum
//   add_c    in   1              adder carry-out
//   rsp_vld  out  N_REQ          one-hot, 1-cycle response strobe to owner
//   rsp_sum  out  WIDTH          registered result sum
//   rsp_c    out  1              registered result carry
//   busy     out  1              any operation issued and not yet responded
// BEHAVIOUR
//   Reset: ptr=0, gnt=0, add_a=add_b=0, issue valid=0, tag pipe all invalid,
//     rsp_vld=0, rsp_sum=0, rsp_c=0, busy=0.
//   Reset mid-operation discards all in-flight ops; no rsp_vld for them.
//   Arbitration:
//     - gnt[i]=1 iff en & req[i] and i is first requester with req set,
//       searching from ptr upward, mod N_REQ.
//     - At most one gnt bit is set.
//     - On a grant to i at a clock edge: ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
//     - A requester holding req continuously is granted within N_REQ cycles
//       (starvation-free).
//   Issue stage:
//     - On grant edge: add_a <= req_a[i], add_b <= req_b[i]; issue valid <= 1, tag <= i.
//     - With no grant: valid <= 0; add_a/add_b hold their value (don't-care to adder).
//   Tag pipe: LAT stages of {valid, tag}, shifted every cycle (never stalls).
//     Its entry is the issue-stage {valid, tag}.
//   Response:
//     - When the tag pipe output is valid: rsp_vld <= onehot(tag),
//       rsp_sum <= add_sum, rsp_c <= add_c. Otherwise rsp_vld <= 0 and sum/c hold.
//   Latency: grant in cycle t -> operands on add_* in t+1 -> adder result in t+1+LAT
//     -> rsp_vld in cycle t+2+LAT (6 cycles at LAT=4).
//   Throughput: 1 op/cycle; back-to-back grants give back-to-back responses in grant order.
//   Responses cannot be back-pressured; requesters must accept rsp_vld when strobed.
//   busy = issue valid | any tag-pipe valid | rsp_vld != 0.
//   en deasserted: no grants from that cycle on. In-flight ops complete normally.
//   Width: rsp_sum is the full WIDTH sum, rsp_c the carry. No saturation, no overflow
//     flag (e.g. F+1 -> sum 0, c 1).
//   The same requester may be regranted while its earlier op is in flight.
//   Results return in issue order.
// TESTING
//   1 Single op: req[2], A=3,B=5 at t, model adder LAT=4 -> gnt=4'b0100 at t;
//     rsp_vld=4'b0100, sum=8, c=0 at t+6.
//   2 All four req held 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3;
//     rsp strobes in same order 6 cycles later.
//   3 Overflow: A=F,B=1 -> sum=0,c=1; A=F,B=F -> sum=E,c=1.
//   4 en=0 with req[1] high -> gnt=0, busy falls after in-flight drain.
//     en=1 -> grant next cycle.
//   5 Assert RST_n low 3 cycles after 3 back-to-back issues -> all outputs 0 immediately;
//     no rsp_vld after release.
//   6 Only req[3] held continuously -> granted every cycle;
//     rsp_vld[3] high on 4 consecutive cycles for 4 distinct operand pairs.

Source files
------------

// File: rtl/adder_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined adder.
// Ports: CLK/RST_n, en, req/req_a/req_b in, gnt, add_a/add_b, add_sum/add_c, rsp_*, busy.
module adder_pipe_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int LAT   = 4
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_c,
  output logic [N_REQ-1:0]         rsp_vld,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_c,
  output logic                     busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           gnt_idx;
  logic                    gnt_any;
  int                      idx;

  logic                    iss_vld_q, iss_vld_d;
  logic [PW-1:0]           iss_tag_q, iss_tag_d;
  logic [WIDTH-1:0]        add_a_q, add_a_d;
  logic [WIDTH-1:0]        add_b_q, add_b_d;

  logic [LAT-1:0]          pv_q, pv_d;
  logic [LAT-1:0][PW-1:0]  pt_q, pt_d;

  logic [N_REQ-1:0]        rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0]        rsp_sum_q, rsp_sum_d;
  logic                    rsp_c_q, rsp_c_d;

  // First requester at or above ptr, wrapping; gated by reset so
  // gnt reads 0 while RST_n is low.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_any && req[idx] && en && RST_n) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PW'(N_REQ - 1)) ptr_d = '0;
      else                           ptr_d = gnt_idx + PW'(1);
    end
  end

  always_comb begin
    iss_vld_d = gnt_any;
    iss_tag_d = gnt_idx;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    if (gnt_any) begin
      add_a_d = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
      add_b_d = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  // Owner tags ride alongside the adder so the last stage lines up
  // with the cycle add_sum/add_c are valid.
  always_comb begin
    pv_d    = pv_q;
    pt_d    = pt_q;
    pv_d[0] = iss_vld_q;
    pt_d[0] = iss_tag_q;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
  end

  always_comb begin
    rsp_vld_d = '0;
    rsp_sum_d = rsp_sum_q;
    rsp_c_d   = rsp_c_q;
    if (pv_q[LAT-1]) begin
      rsp_vld_d[pt_q[LAT-1]] = 1'b1;
      rsp_sum_d              = add_sum;
      rsp_c_d                = add_c;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ptr_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      pv_q      <= '0;
      pt_q      <= '0;
      rsp_vld_q <= '0;
      rsp_sum_q <= '0;
      rsp_c_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= iss_vld_d;
      iss_tag_q <= iss_tag_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      pv_q      <= pv_d;
      pt_q      <= pt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_c_q   <= rsp_c_d;
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_sum = rsp_sum_q;
  assign rsp_c   = rsp_c_q;
  assign busy    = iss_vld_q | (|pv_q) | (|rsp_vld_q);

endmodule
